// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample type and I2S frame geometry
package audio_pkg;

  typedef shortint sample_t;

  function automatic int frame_len(input int slot_bits, input int bclk_div);
    return 2 * slot_bits * bclk_div;
  endfunction

  localparam int FRAME = frame_len(32, 4);
  localparam int CNT_W = $clog2(FRAME);

endpackage

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - sample-pair stream from the source stages into i2s_tx
interface i2s_tx_if #(
  parameter int SAMPLE_BITS = 16
);
  import audio_pkg::*;

  logic signed [SAMPLE_BITS-1:0] p_sample_l;
  logic signed [SAMPLE_BITS-1:0] p_sample_r;
  logic                          valid;
  logic                          sample_req;

  modport master (output p_sample_l, output p_sample_r, output valid, input sample_req);
  modport slave  (input p_sample_l, input p_sample_r, input valid, output sample_req);

endinterface

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - frame counter (mclk divider, slot, channel) with registered bclk/lrclk
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic                         mclk,
  input  logic                         rst,
  output logic                         bclk,
  output logic                         lrclk,
  output logic [$clog2(SLOT_BITS)-1:0] slot,
  output logic                         bit_last,
  output logic                         boundary
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int SW = $clog2(SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_BITS - 1);

  // The frame count c is held as {lr, slot, div} so no wide divide is needed.
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          lr_q, lr_d;
  logic          bclk_q, bclk_d;

  always_comb begin
    div_d  = div_q + 1'b1;
    slot_d = slot_q;
    lr_d   = lr_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      slot_d = slot_q + 1'b1;
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        lr_d   = ~lr_q;
      end
    end
    bclk_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      slot_q <= '0;
      lr_q   <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
      lr_q   <= lr_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lr_q;
  assign slot     = slot_q;
  assign bit_last = (div_q == DIV_LAST);
  assign boundary = lr_q & (slot_q == SLOT_LAST) & (div_q == DIV_LAST);

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - stereo I2S transmitter: pending/active sample buffers and MSB-first shifter
// I2S_TX_UNDERRUN_MUTE_EN: on underrun send silence instead of repeating the last pair.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_DIV    = 4
) (
  input  logic     mclk,
  input  logic     rst,
  i2s_tx_if.slave  src,
  output logic     underrun,
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata
);

  localparam int SW = $clog2(SLOT_BITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SAMP_LIM  = SW'(SAMPLE_BITS);

  logic          bit_last;
  logic          boundary;
  logic [SW-1:0] slot;

  i2s_clkgen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV)
  ) u_clkgen (
    .mclk     (mclk),
    .rst      (rst),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .slot     (slot),
    .bit_last (bit_last),
    .boundary (boundary)
  );

  logic signed [SAMPLE_BITS-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic signed [SAMPLE_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                          pend_full_q, pend_full_d;
  logic                          under_q, under_d;
  logic                          req_q, req_d;
  logic        [SAMPLE_BITS-1:0] sh_q, sh_d;
  logic                          sdata_q, sdata_d;

  always_comb begin
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    under_d     = 1'b0;
    req_d       = 1'b0;

    if (boundary) begin
      req_d = 1'b1;
      // A pair arriving on the boundary itself bypasses the pending slot.
      if (src.valid) begin
        act_l_d     = src.p_sample_l;
        act_r_d     = src.p_sample_r;
        pend_full_d = 1'b0;
      end else if (pend_full_q) begin
        act_l_d     = pend_l_q;
        act_r_d     = pend_r_q;
        pend_full_d = 1'b0;
      end else begin
        under_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        act_l_d = '0;
        act_r_d = '0;
`else
        act_l_d = act_l_q;
        act_r_d = act_r_q;
`endif
      end
    end else if (src.valid) begin
      pend_l_d    = src.p_sample_l;
      pend_r_d    = src.p_sample_r;
      pend_full_d = 1'b1;
    end
  end

  // sdata moves only when the next slot begins, one bclk behind lrclk.
  always_comb begin
    sh_d    = sh_q;
    sdata_d = sdata_q;
    if (bit_last) begin
      if (slot == SLOT_LAST) begin
        sdata_d = 1'b0;
        sh_d    = lrclk ? act_l_d : act_r_d;
      end else if (slot < SAMP_LIM) begin
        sdata_d = sh_q[SAMPLE_BITS-1];
        sh_d    = sh_q << 1;
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      under_q     <= 1'b0;
      req_q       <= 1'b0;
      sh_q        <= '0;
      sdata_q     <= 1'b0;
    end else begin
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_full_q <= pend_full_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      under_q     <= under_d;
      req_q       <= req_d;
      sh_q        <= sh_d;
      sdata_q     <= sdata_d;
    end
  end

  assign underrun       = under_q;
  assign src.sample_req = req_q;
  assign sdata          = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed and random checks of i2s_tx against a frame-level reference model
`timescale 1ns/1ps
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int SB   = 16;
  localparam int SLOT = 32;
  localparam int DIV  = 4;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic mclk = 1'b0;
  logic rst  = 1'b0;
  logic underrun, bclk, lrclk, sdata;

  i2s_tx_if #(.SAMPLE_BITS(SB)) sif ();

  i2s_tx #(
    .SAMPLE_BITS (SB),
    .SLOT_BITS   (SLOT),
    .BCLK_DIV    (DIV)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .src      (sif.slave),
    .underrun (underrun),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;

  logic [CNT_W-1:0] m_c;
  sample_t          m_al, m_ar, m_pl, m_pr;
  bit               m_pf;
  logic [SB-1:0]    cap_l, cap_r, last_l, last_r;
  int               under_cnt, req_cnt, lr_hi_cnt, bclk_hi_cnt;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @c=%0d: observed %b expected %b", tag, m_c, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [SB-1:0] obs, input logic [SB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_c   = '0;
    m_al  = 0;
    m_ar  = 0;
    m_pl  = 0;
    m_pr  = 0;
    m_pf  = 1'b0;
    cap_l = '0;
    cap_r = '0;
  endtask

  // One mclk: present inputs, advance the model across the edge, check every output.
  task automatic tick(input logic v, input sample_t l, input sample_t r);
    logic          e_req, e_under, e_lr, e_sd;
    logic [SB-1:0] w;
    int            s, ci;
    sif.valid      = v;
    sif.p_sample_l = l;
    sif.p_sample_r = r;
    @(posedge mclk);
    e_req   = 1'b0;
    e_under = 1'b0;
    if (int'(m_c) == FRAME - 1) begin
      e_req = 1'b1;
      if (v) begin
        m_al = l; m_ar = r; m_pf = 1'b0;
      end else if (m_pf) begin
        m_al = m_pl; m_ar = m_pr; m_pf = 1'b0;
      end else begin
        e_under = 1'b1;
        if (MUTE) begin
          m_al = 0; m_ar = 0;
        end
      end
      m_c = '0;
    end else begin
      if (v) begin
        m_pl = l; m_pr = r; m_pf = 1'b1;
      end
      m_c = m_c + 1'b1;
    end
    #1;
    ci   = int'(m_c);
    s    = (ci / DIV) % SLOT;
    e_lr = (ci >= SLOT * DIV);
    w    = e_lr ? m_ar : m_al;
    e_sd = (s >= 1 && s <= SB) ? w[SB-s] : 1'b0;
    chk_bit("bclk", bclk, (ci % DIV) >= DIV / 2);
    chk_bit("lrclk", lrclk, e_lr);
    chk_bit("sdata", sdata, e_sd);
    chk_bit("sample_req", sif.sample_req, e_req);
    chk_bit("underrun", underrun, e_under);
    if (underrun) under_cnt++;
    if (sif.sample_req) req_cnt++;
    if (lrclk) lr_hi_cnt++;
    if (bclk) bclk_hi_cnt++;
    if ((ci % DIV) == DIV / 2 && s >= 1 && s <= SB) begin
      if (e_lr) cap_r = {cap_r[SB-2:0], sdata};
      else      cap_l = {cap_l[SB-2:0], sdata};
    end
    if (ci == FRAME - 1) begin
      last_l = cap_l;
      last_r = cap_r;
      cap_l  = '0;
      cap_r  = '0;
    end
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < FRAME && int'(m_c) != target; n++) tick(1'b0, 0, 0);
  endtask

  initial begin
    int req0, lr0, bh0;
    sif.valid      = 1'b0;
    sif.p_sample_l = '0;
    sif.p_sample_r = '0;
    under_cnt = 0; req_cnt = 0; lr_hi_cnt = 0; bclk_hi_cnt = 0;
    model_reset();

    repeat (3) @(posedge mclk);
    #1;
    chk_bit("rst_bclk", bclk, 1'b0);
    chk_bit("rst_lrclk", lrclk, 1'b0);
    chk_bit("rst_sdata", sdata, 1'b0);
    chk_bit("rst_req", sif.sample_req, 1'b0);
    chk_bit("rst_under", underrun, 1'b0);
    rst = 1'b1;

    // Pair loaded at c=10 goes out in the next frame; the first frame is silent.
    run_to(10);
    tick(1'b1, 16'h8001, 16'h7FFE);
    run_to(FRAME - 1);
    chk_word("frame1_l", last_l, 16'h0000);
    chk_word("frame1_r", last_r, 16'h0000);
    tick(1'b0, 0, 0);
    chk_bit("no_under_first", underrun, 1'b0);
    run_to(50);
    tick(1'b1, 16'h1234, 16'h4321);
    run_to(FRAME - 1);
    chk_word("frame2_l", last_l, 16'h8001);
    chk_word("frame2_r", last_r, 16'h7FFE);

    // Frame 3 carries 1234 with nothing queued behind it.
    tick(1'b0, 0, 0);
    run_to(FRAME - 1);
    chk_word("frame3_l", last_l, 16'h1234);
    tick(1'b0, 0, 0);
    chk_bit("underrun_pulse", underrun, 1'b1);
    chk_bit("req_on_underrun", sif.sample_req, 1'b1);
    run_to(20);
    tick(1'b1, 16'h5555, 16'h5555);
    run_to(FRAME - 1);
    chk_word("frame4_l", last_l, MUTE ? 16'h0000 : 16'h1234);
    chk_word("frame4_r", last_r, MUTE ? 16'h0000 : 16'h4321);

    // Pair on the boundary cycle beats the pending 5555.
    tick(1'b1, 16'hAAAA, 16'hAAAA);
    chk_bit("no_under_bypass", underrun, 1'b0);
    run_to(30);
    tick(1'b1, 16'h0001, 16'h0001);
    run_to(90);
    tick(1'b1, 16'h0002, 16'h0002);
    run_to(FRAME - 1);
    chk_word("frame5_l", last_l, 16'hAAAA);
    chk_word("frame5_r", last_r, 16'hAAAA);
    tick(1'b0, 0, 0);
    run_to(FRAME - 1);
    chk_word("frame6_l", last_l, 16'h0002);
    chk_int("underrun_count", under_cnt, 1);

    // Mid-frame asynchronous reset.
    tick(1'b0, 0, 0);
    run_to(137);
    #1 rst = 1'b0;
    #1;
    chk_bit("mid_rst_bclk", bclk, 1'b0);
    chk_bit("mid_rst_lrclk", lrclk, 1'b0);
    chk_bit("mid_rst_sdata", sdata, 1'b0);
    chk_bit("mid_rst_req", sif.sample_req, 1'b0);
    chk_bit("mid_rst_under", underrun, 1'b0);
    @(posedge mclk);
    #1;
    rst = 1'b1;
    model_reset();
    run_to(127);
    chk_bit("lr_before_128", lrclk, 1'b0);
    tick(1'b0, 0, 0);
    chk_bit("lr_at_128", lrclk, 1'b1);
    run_to(FRAME - 1);
    chk_word("post_rst_l", last_l, 16'h0000);
    tick(1'b0, 0, 0);
    chk_bit("post_rst_req", sif.sample_req, 1'b1);

    // Free-running random traffic, including frames with no pair at all.
    run_to(FRAME - 1);
    req0 = req_cnt;
    lr0  = lr_hi_cnt;
    bh0  = bclk_hi_cnt;
    for (int i = 0; i < 24 * FRAME; i++) begin
      tick(($urandom_range(0, 149) == 0), sample_t'($urandom), sample_t'($urandom));
    end
    chk_int("req_per_frame", req_cnt - req0, 24);
    chk_int("lrclk_duty", lr_hi_cnt - lr0, 24 * FRAME / 2);
    chk_int("bclk_duty", bclk_hi_cnt - bh0, 24 * FRAME / 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter at the end of the audio chain, consuming the `shortint` sample/valid stream produced by the source stages (sine player, volume adjust) and serialising it to the codec. Runs entirely in the `mclk` domain (256x sample rate), derives `bclk` and `lrclk` by counting, double-buffers one sample pair and reports underrun. Sits between the source/mixer output and the codec pins.

## Interface
- `SAMPLE_BITS`, 16: sample width, MSB-first; must be ≤ `SLOT_BITS`-1.
- `SLOT_BITS`, 32: bclk periods per channel half-frame.
- `BCLK_DIV`, 4: mclk cycles per bclk, even, ≥2; frame length FRAME = 2·SLOT_BITS·BCLK_DIV (default 256).

- `mclk`  in  1  master clock, 256x sample rate.
- `rst`  in  1  reset, asynchronous, active-low.
- `p_sample_l`  in  SAMPLE_BITS  left sample, signed.
- `p_sample_r`  in  SAMPLE_BITS  right sample, signed.
- `valid`  in  1  sample pair present this cycle; single-cycle qualifier.
- `sample_req`  out  1  one-cycle pulse: active pair just loaded, pending slot free.
- `underrun`  out  1  one-cycle pulse: frame started with no new pair.
- `bclk`  out  1  bit clock.
- `lrclk`  out  1  word select, 0 = left, 1 = right.
- `sdata`  out  1  serial data.

## Operation
- Frame counter `c`, 0..FRAME-1, +1 per mclk, wraps FRAME-1→0.
- Decode of `c`: `bclk` = (c mod BCLK_DIV) ≥ BCLK_DIV/2; slot s = (c / BCLK_DIV) mod SLOT_BITS; `lrclk` = c ≥ SLOT_BITS·BCLK_DIV; `sdata` = word[SAMPLE_BITS-s] for 1 ≤ s ≤ SAMPLE_BITS, else 0 (word = active L or R by `lrclk`). Standard I2S one-bclk delay; unused slots zero.
- Pending slot: `valid`=1 writes (L,R) into pending, sets pending_full. Valid while full overwrites (newest wins), no flag.
- Frame boundary (edge where c = FRAME-1): if `valid` that cycle, active ← inputs directly, pending_full cleared; else if pending_full, active ← pending, cleared; else underrun case (see Configuration), `underrun` pulses.
- `sample_req` pulses in the cycle c = 0 regardless of underrun.
- Active words change only at the boundary; mid-frame `valid` never alters bits on the wire.

## Timing
- Reset (async assert, any time): c=0, `bclk`=0, `lrclk`=0, `sdata`=0, `sample_req`=0, `underrun`=0, active L/R = 0, pending empty. Mid-frame reset truncates the frame; no recovery sequence.
- First edge after deassert: c→1; first full frame transmits zeros unless `valid` arrives before c = FRAME-1.
- All outputs are flops; in the cycle the counter holds c, each output shows its decode of c (computed from next count). No combinational input→output paths.
- `bclk` falls at c mod BCLK_DIV = 0; `lrclk`/`sdata` change only there, stable across every `bclk` rising edge.
- Latency: pair accepted at or before c = FRAME-1 has its left MSB on `sdata` during c = BCLK_DIV..2·BCLK_DIV-1 of the next frame.

## Configuration
- `I2S_TX_UNDERRUN_MUTE_EN` defined: on underrun active L/R ← 0 (silence).
- Undefined: on underrun active L/R hold previous values (last pair repeated). `underrun` pulses in both builds.

## Structure
- Package `audio_pkg`: `typedef shortint sample_t`; localparams FRAME default 256, counter width `$clog2(FRAME)`.
- Sub-module `i2s_clkgen`: frame counter plus registered `bclk`/`lrclk`/slot-index/boundary decode; `i2s_tx` holds pending/active buffers and data shifter.

## Test plan
- Reset then L=16'h8001, R=16'h7FFE valid at c=10 → next frame samples at `bclk` rising: left slots 1..16 = 1000…0001, right = 0111…1110, slots 0 and 17..31 = 0.
- No `valid` for one frame after L=16'h1234 → `underrun` pulse at c=0; repeats 16'h1234 (macro off) / sends all-zero (macro on).
- `valid` at c=FRAME-1 with L=16'hAAAA while pending holds 16'h5555 → 16'hAAAA transmitted, no `underrun`.
- Two `valid` pulses in one frame (16'h0001 then 16'h0002) → only 16'h0002 transmitted; current frame bits unchanged.
- Assert `rst` low at c=137 → all outputs 0 immediately; after release `lrclk` rises at c=128, `sample_req` at next c=0.
- Free-running: `bclk` period 4 mclk, `lrclk` period 256 mclk, 50% duty, `sample_req` every 256 mclk.
